ysyx_23060096_core_ctrl: RTL and testbench
==========================================

Name: ysyx_23060096_core_ctrl

Overview:
Multi-cycle sequencer for the single-cycle NPC datapath (PC, decoder, immediate generator, register file, ALU).
- Runs a FETCH / EXEC / MEM / HALT state machine.
- Holds the fetched instruction in a local register.
- Gates PC and register-file write enables so each instruction commits exactly once.
- Handshakes with the instruction-fetch and load/store memory ports.
- Stops the core on ebreak, on an illegal opcode, or on a stalled memory port (watchdog).

Parameters:
- TIMEOUT_CYCLES, 1024, maximum consecutive wait cycles in FETCH or MEM before forced halt; must be at least 2.
- NOP_INST, 32'h0000_0013, reset value of the instruction register (addi x0,x0,0).

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- ifu_req  output  1  fetch request; held high until ifu_rvalid
- ifu_rvalid  input  1  fetch data valid
- ifu_rdata  input  32  fetched instruction
- inst  output  32  latched instruction driven to decoder and immediate generator
- lsu_req  output  1  data-memory request; held high until lsu_ack
- lsu_we  output  1  1 = store, 0 = load; valid while lsu_req is high
- lsu_ack  input  1  data-memory completion, for both loads and stores
- rf_we_in  input  1  RegWr from the control generator
- rf_we  output  1  gated register-file write enable
- pc_we  output  1  PC update strobe
- a0_val  input  32  current x10 value, used as the halt return code
- halt  output  1  core stopped (sticky)
- halt_code  output  2  0 = good trap, 1 = bad trap, 2 = illegal instruction, 3 = timeout
- mcycle  output  64  cycle counter (optional feature)
- minstret  output  64  retired-instruction counter (optional feature)

Behaviour:
Reset (rstn = 0, asynchronous):
- State returns to FETCH.
- inst = NOP_INST; halt_code = 0.
- All strobes (ifu_req, lsu_req, rf_we, pc_we, halt) = 0; watchdog = 0.
- Reset asserted mid-FETCH or mid-MEM aborts the transaction; no commit occurs.

FETCH:
- ifu_req = 1.
- On ifu_rvalid: latch ifu_rdata into inst, go to EXEC.
- ifu_rvalid seen outside FETCH is ignored.

EXEC (exactly 1 cycle). Decode inst[6:0] into one of these cases:
- Opcodes LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP: rf_we = rf_we_in, pc_we = 1, go to FETCH.
- LOAD (0000011) or STORE (0100011): go to MEM with lsu_req = 1, lsu_we = (opcode == STORE).
- inst == 32'h0010_0073 (ebreak): go to HALT; halt_code = 0 if a0_val == 0, else 1. No pc_we.
- Any other value, including other SYSTEM encodings: go to HALT with halt_code = 2.

MEM:
- lsu_req and lsu_we held stable until lsu_ack.
- On lsu_ack, in the same cycle: pc_we = 1; rf_we = rf_we_in & ~lsu_we. Then go to FETCH.

HALT:
- Terminal state; halt = 1.
- All strobes 0; inputs ignored until reset.

Strobes and latency:
- rf_we and pc_we are 1-cycle pulses, at most once per instruction, always in the same cycle.
- Minimum ALU-instruction latency is 2 cycles (ifu_rvalid in the first FETCH cycle, then EXEC).
- Load/store minimum latency is 3 cycles.

Watchdog:
- Counts consecutive cycles in FETCH or MEM without the matching valid/ack.
- Clears on any state change.
- When the count reaches TIMEOUT_CYCLES - 1 with no valid/ack: next state is HALT with halt_code = 3.
- A valid/ack arriving in that same cycle wins over the timeout.

Optional Feature:
- Macro: YSYX_23060096_PERF_CNT_EN.
- Defined:
  - mcycle increments every cycle while not in HALT.
  - minstret increments on each pc_we pulse.
  - Both 64-bit, reset to 0, wrap modulo 2^64, and freeze in HALT.
- Undefined: mcycle and minstret are tied to 0 and no counter flops are built.

Decomposition:
- Package ysyx_23060096_pkg holds:
  - state enum (FETCH, EXEC, MEM, HALT, 2 bits);
  - opcode localparams;
  - EBREAK_INST;
  - halt-code constants (HALT_GOOD, HALT_BAD, HALT_ILL, HALT_TIMEOUT).
- One sub-module, ysyx_23060096_watchdog: parameterised counter with inputs clear and wait, output expired.

Test Plan:
- ALU op: ifu_rdata = 32'h0050_0093 (addi x1,x0,5), rvalid in the first FETCH cycle, rf_we_in = 1 -> rf_we and pc_we pulse together in the EXEC cycle (cycle 2); ifu_req reasserts the next cycle.
- Store: inst 32'h0011_2023, lsu_ack 3 cycles after entering MEM -> lsu_req high for exactly 4 cycles with lsu_we = 1; pc_we = 1 and rf_we = 0 in the ack cycle.
- Load: inst 32'h0001_2083, rf_we_in = 1, lsu_ack after 1 cycle -> rf_we = 1 with pc_we in the ack cycle.
- Ebreak: inst 32'h0010_0073 with a0_val = 0 -> halt = 1, halt_code = 0; repeat with a0_val = 7 -> halt_code = 1; no pc_we in either case.
- Illegal and timeout: inst 32'hFFFF_FFFF -> halt_code = 2. Separately, hold ifu_rvalid = 0 with TIMEOUT_CYCLES = 16 -> halt after 16 FETCH cycles with halt_code = 3.
- Reset and counters: assert rstn low mid-MEM -> all outputs return to reset values asynchronously and inst = 32'h0000_0013. With YSYX_23060096_PERF_CNT_EN, after 10 ALU instructions at 2 cycles each: minstret = 10, mcycle = 20.

Source files
------------

// File: rtl/ysyx_23060096_core_ctrl_pkg.sv
// ysyx_23060096_pkg
// Shared definitions for the NPC multi-cycle sequencer:
//   state_e      - sequencer state (FETCH, EXEC, MEM, HALT)
//   OP_*         - RV32I major opcodes the sequencer distinguishes
//   EBREAK_INST  - the only SYSTEM encoding that halts cleanly
//   HALT_*       - values reported on halt_code
//   is_alu_op()  - opcodes that complete in EXEC without memory access
package ysyx_23060096_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [1:0] HALT_GOOD    = 2'd0;
  localparam logic [1:0] HALT_BAD     = 2'd1;
  localparam logic [1:0] HALT_ILL     = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_LUI)    || (op == OP_AUIPC) || (op == OP_JAL) ||
           (op == OP_JALR)   || (op == OP_BRANCH) || (op == OP_IMM) ||
           (op == OP_OP);
  endfunction

endpackage

// File: rtl/ysyx_23060096_core_ctrl_if.sv
// ysyx_23060096_core_ctrl_if
// Instruction-fetch and load/store memory handshakes of the sequencer.
//   ifu_req/ifu_rvalid/ifu_rdata : fetch request, data valid, instruction word
//   lsu_req/lsu_we/lsu_ack       : data request, 1 = store, completion
// Handshake rule: a request (ifu_req, lsu_req) is raised by the master and
// held, with lsu_we stable, until the slave answers with a one-cycle
// ifu_rvalid / lsu_ack; the transfer completes in the cycle both are high.
// Answers that arrive while no request is pending are ignored.
// Modports: master = sequencer side, slave = memory side.
interface ysyx_23060096_core_ctrl_if;
  logic        ifu_req;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_ack;

  modport master (
    output ifu_req,
    input  ifu_rvalid,
    input  ifu_rdata,
    output lsu_req,
    output lsu_we,
    input  lsu_ack
  );

  modport slave (
    input  ifu_req,
    output ifu_rvalid,
    output ifu_rdata,
    input  lsu_req,
    input  lsu_we,
    output lsu_ack
  );
endinterface

// File: rtl/ysyx_23060096_core_ctrl_watchdog.sv
// ysyx_23060096_watchdog
// Counts consecutive wait cycles; expired is raised in the cycle where the
// count has reached TIMEOUT_CYCLES-1 and the wait is still unanswered.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : restart the count (owner changed state)
//   wait_en   : current cycle is an unanswered wait cycle
//   expired   : wait budget used up in this cycle
module ysyx_23060096_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic wait_en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so the counter cannot wrap even if the owner ignores
  // expired.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wait_en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = wait_en && (count == LAST);

endmodule

// File: rtl/ysyx_23060096_core_ctrl.sv
// ysyx_23060096_core_ctrl
// Multi-cycle sequencer for the NPC datapath: FETCH -> EXEC (-> MEM) -> FETCH,
// with a terminal HALT on ebreak, illegal opcode or memory-port timeout.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   bus (master) : fetch and load/store handshakes
//   inst         : latched instruction for decoder / immediate generator
//   rf_we_in     : RegWr from the control generator
//   rf_we, pc_we : one-shot commit strobes, always together
//   a0_val       : x10, used as the ebreak return code
//   halt         : sticky stop flag; halt_code gives the reason
//   mcycle, minstret : performance counters
//   dbg_state    : current sequencer state
// Macro YSYX_23060096_PERF_CNT_EN builds the performance counters; without it
// mcycle/minstret read 0 and no counter flops exist.
module ysyx_23060096_core_ctrl
  import ysyx_23060096_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rstn,
  ysyx_23060096_core_ctrl_if.master bus,
  output logic [31:0]               inst,
  input  logic                      rf_we_in,
  output logic                      rf_we,
  output logic                      pc_we,
  input  logic [31:0]               a0_val,
  output logic                      halt,
  output logic [1:0]                halt_code,
  output logic [63:0]               mcycle,
  output logic [63:0]               minstret,
  output state_e                    dbg_state
);

  state_e      state, state_nxt;
  logic [31:0] inst_nxt;
  logic [1:0]  code_nxt;
  logic        ifu_req_c, lsu_req_c, lsu_we_c, rf_we_c, pc_we_c;
  logic        wd_wait, wd_expired;
  logic [6:0]  opcode;
  logic        is_store;

  assign opcode   = inst[6:0];
  assign is_store = (opcode == OP_STORE);

  // Kept outside the FSM process so the watchdog's expired feedback does not
  // form a loop through a single combinational block.
  assign wd_wait = ((state == FETCH) && !bus.ifu_rvalid) ||
                   ((state == MEM)   && !bus.lsu_ack);

  ysyx_23060096_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_nxt != state),
    .wait_en(wd_wait),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FETCH;
      inst      <= NOP_INST;
      halt_code <= HALT_GOOD;
    end else begin
      state     <= state_nxt;
      inst      <= inst_nxt;
      halt_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    inst_nxt  = inst;
    code_nxt  = halt_code;
    ifu_req_c = 1'b0;
    lsu_req_c = 1'b0;
    lsu_we_c  = 1'b0;
    rf_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    case (state)
      FETCH: begin
        ifu_req_c = 1'b1;
        // A valid arriving on the last allowed cycle beats the timeout.
        if (bus.ifu_rvalid) begin
          inst_nxt  = bus.ifu_rdata;
          state_nxt = EXEC;
        end else if (wd_expired) begin
          state_nxt = HALT;
          code_nxt  = HALT_TIMEOUT;
        end
      end
      EXEC: begin
        if (inst == EBREAK_INST) begin
          state_nxt = HALT;
          code_nxt  = (a0_val == 32'd0) ? HALT_GOOD : HALT_BAD;
        end else if (is_alu_op(opcode)) begin
          rf_we_c   = rf_we_in;
          pc_we_c   = 1'b1;
          state_nxt = FETCH;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_nxt = MEM;
        end else begin
          state_nxt = HALT;
          code_nxt  = HALT_ILL;
        end
      end
      MEM: begin
        lsu_req_c = 1'b1;
        lsu_we_c  = is_store;
        if (bus.lsu_ack) begin
          pc_we_c   = 1'b1;
          rf_we_c   = rf_we_in && !is_store;
          state_nxt = FETCH;
        end else if (wd_expired) begin
          state_nxt = HALT;
          code_nxt  = HALT_TIMEOUT;
        end
      end
      default: begin
        // HALT: terminal until reset, every strobe stays low.
      end
    endcase
  end

  // Reset parks the FSM in FETCH, which would otherwise raise ifu_req while
  // rstn is still low; masking it keeps every strobe at 0 during reset.
  assign bus.ifu_req = ifu_req_c && rstn;
  assign bus.lsu_req = lsu_req_c;
  assign bus.lsu_we  = lsu_we_c;
  assign rf_we       = rf_we_c;
  assign pc_we       = pc_we_c;
  assign halt        = (state == HALT);
  assign dbg_state   = state;

`ifdef YSYX_23060096_PERF_CNT_EN
  logic [63:0] mcycle_q, minstret_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (state != HALT) mcycle_q <= mcycle_q + 64'd1;
      if (pc_we_c)       minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`else
  assign mcycle   = '0;
  assign minstret = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060096_core_ctrl.sv
module tb_ysyx_23060096_core_ctrl;
  localparam int          T    = 16;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3, K_ILL = 4;

  // One expected output event per instruction: a commit (pc_we) or a halt.
  typedef struct packed {
    logic        is_halt;
    logic        rf;
    logic [1:0]  code;
    logic        st;
    logic [31:0] inst;
    logic [15:0] lat;
    logic [15:0] memc;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rstn;
  logic        rf_we_in;
  logic [31:0] a0_val;
  logic [31:0] inst;
  logic        rf_we, pc_we, halt;
  logic [1:0]  halt_code;
  logic [63:0] mcycle, minstret;
  ysyx_23060096_pkg::state_e dbg_state;

  ysyx_23060096_core_ctrl_if bus ();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ysyx_23060096_core_ctrl #(
    .TIMEOUT_CYCLES(T),
    .NOP_INST      (NOP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .inst     (inst),
    .rf_we_in (rf_we_in),
    .rf_we    (rf_we),
    .pc_we    (pc_we),
    .a0_val   (a0_val),
    .halt     (halt),
    .halt_code(halt_code),
    .mcycle   (mcycle),
    .minstret (minstret),
    .dbg_state(dbg_state)
  );

  initial begin
    #800000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int          m_commits;
  int          m_cycles;
  logic [31:0] last_inst;

  function automatic int classify(input logic [31:0] i);
    if (i == EBRK) return K_EBRK;
    case (i[6:0])
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33: return K_ALU;
      7'h03: return K_LD;
      7'h23: return K_ST;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    int r;
    v = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 4) begin
      case ($urandom_range(0, 6))
        0: v[6:0] = 7'h37;
        1: v[6:0] = 7'h17;
        2: v[6:0] = 7'h6f;
        3: v[6:0] = 7'h67;
        4: v[6:0] = 7'h63;
        5: v[6:0] = 7'h13;
        default: v[6:0] = 7'h33;
      endcase
    end else if (r == 5) begin
      v[6:0] = 7'h03;
    end else if (r == 6) begin
      v[6:0] = 7'h23;
    end else if (r == 7) begin
      v = EBRK;
    end else if (r == 9) begin
      v = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'hFFFF_FFFF;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered in a FETCH cycle (posedge+1). fd = fetch wait cycles, md = MEM
  // wait cycles before ack; fd or md >= T exercises the watchdog.
  task automatic run_inst(input logic [31:0] i, input logic rwi, input logic [31:0] a0,
                          input int fd, input int md, output bit halted);
    exp_t e;
    int   k;
    k = classify(i);
    e = '0;
    halted = 1'b0;
    if (fd >= T) begin
      e.is_halt = 1'b1; e.code = 2'd3; e.inst = last_inst; e.lat = 16'(T + 1);
    end else begin
      e.inst = i;
      case (k)
        K_ALU: begin e.rf = rwi; e.lat = 16'(fd + 2); end
        K_LD, K_ST: begin
          e.st = (k == K_ST);
          if (md >= T) begin
            e.is_halt = 1'b1; e.code = 2'd3; e.lat = 16'(fd + T + 3); e.memc = 16'(T);
          end else begin
            e.rf = rwi && (k == K_LD); e.lat = 16'(fd + md + 3); e.memc = 16'(md + 1);
          end
        end
        K_EBRK: begin e.is_halt = 1'b1; e.code = (a0 != 0) ? 2'd1 : 2'd0; e.lat = 16'(fd + 3); end
        default: begin e.is_halt = 1'b1; e.code = 2'd2; e.lat = 16'(fd + 3); end
      endcase
      last_inst = i;
    end
    if (e.is_halt) m_cycles += int'(e.lat) - 1;
    else begin m_cycles += int'(e.lat); m_commits++; end
    exp_q.push_back(EW'(e));

    rf_we_in = rwi;
    a0_val   = a0;
    repeat ((fd >= T) ? T : fd) begin
      bus.ifu_rvalid = 1'b0;
      bus.ifu_rdata  = $urandom;
      tick();
    end
    if (fd >= T) begin
      halted = 1'b1;
      return;
    end
    bus.ifu_rvalid = 1'b1;
    bus.ifu_rdata  = i;
    tick();
    // EXEC: a stray valid here must be ignored.
    bus.ifu_rvalid = 1'($urandom_range(0, 1));
    bus.ifu_rdata  = $urandom;
    tick();
    bus.ifu_rvalid = 1'b0;
    if (k == K_LD || k == K_ST) begin
      repeat ((md >= T) ? T : md) begin
        bus.lsu_ack = 1'b0;
        tick();
      end
      if (md >= T) begin
        halted = 1'b1;
        return;
      end
      bus.lsu_ack = 1'b1;
      tick();
      bus.lsu_ack = 1'b0;
    end else if (k != K_ALU) begin
      halted = 1'b1;
    end
  endtask

  task automatic do_reset;
    rstn           = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = '0;
    bus.lsu_ack    = 1'b0;
    rf_we_in       = 1'b0;
    a0_val         = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ifu_req", bus.ifu_req, 0);
    check("rst_lsu_req", bus.lsu_req, 0);
    check("rst_strobes", {rf_we, pc_we, halt}, 0);
    check("rst_halt_code", halt_code, 0);
    check("rst_inst", inst, NOP);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    m_commits = 0;
    m_cycles  = 0;
    last_inst = NOP;
  endtask

  task automatic end_episode;
    repeat (3) begin
      bus.ifu_rvalid = 1'($urandom_range(0, 1));
      bus.ifu_rdata  = $urandom;
      bus.lsu_ack    = 1'($urandom_range(0, 1));
      rf_we_in       = 1'($urandom_range(0, 1));
      tick();
    end
    bus.ifu_rvalid = 1'b0;
    bus.lsu_ack    = 1'b0;
    check("halt_sticky", halt, 1);
    check("halt_quiet", {bus.ifu_req, bus.lsu_req, rf_we, pc_we}, 0);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
`ifdef YSYX_23060096_PERF_CNT_EN
    check("minstret", minstret, 64'(m_commits));
    check("mcycle", mcycle, 64'(m_cycles));
`else
    check("minstret_off", minstret, 0);
    check("mcycle_off", mcycle, 0);
`endif
  endtask

  // Reset asserted two cycles into a store: everything returns at once.
  task automatic abort_mem;
    bus.ifu_rvalid = 1'b1;
    bus.ifu_rdata  = 32'h0011_2023;
    tick();
    bus.ifu_rvalid = 1'b0;
    tick();
    tick();
    check("abort_in_mem", {bus.lsu_req, bus.lsu_we}, 2'b11);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_req", {bus.ifu_req, bus.lsu_req, bus.lsu_we}, 0);
    check("abort_strobes", {rf_we, pc_we, halt}, 0);
    check("abort_code", halt_code, 0);
    check("abort_inst", inst, NOP);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   start_cyc = 0;
  int   lsu_cnt = 0;
  logic prev_req = 1'b0;
  logic prev_halt = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rstn) begin
      if (bus.ifu_req && !prev_req) begin
        start_cyc = cyc;
        lsu_cnt   = 0;
      end
      if (bus.lsu_req) begin
        lsu_cnt++;
        if (exp_q.size() != 0) begin
          e = exp_t'(exp_q[0]);
          check("lsu_we", bus.lsu_we, e.st);
        end
      end
      if (rf_we) check("rf_we_with_pc_we", pc_we, 1);
      if (pc_we || (halt && !prev_halt)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {pc_we, halt}, 0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("ev_halt", halt, e.is_halt);
          check("ev_pc_we", pc_we, !e.is_halt);
          check("ev_rf_we", rf_we, e.rf);
          check("ev_halt_code", halt_code, e.code);
          check("ev_inst", inst, e.inst);
          check("ev_latency", cyc - start_cyc + 1, e.lat);
          check("ev_lsu_cycles", lsu_cnt, e.memc);
        end
      end
    end
    prev_req  = bus.ifu_req;
    prev_halt = halt;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit h;
    rstn           = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = '0;
    bus.lsu_ack    = 1'b0;
    rf_we_in       = 1'b0;
    a0_val         = '0;
    m_commits      = 0;
    m_cycles       = 0;
    last_inst      = NOP;

    // addi, store (ack 3 cycles into MEM), load (ack after 1), ebreak a0=0
    do_reset();
    run_inst(32'h0050_0093, 1'b1, 32'd0, 0, 0, h);
    run_inst(32'h0011_2023, 1'b1, 32'd0, 0, 3, h);
    run_inst(32'h0001_2083, 1'b1, 32'd0, 0, 1, h);
    run_inst(EBRK, 1'b0, 32'd0, 0, 0, h);
    end_episode();

    do_reset();
    run_inst(EBRK, 1'b1, 32'd7, 1, 0, h);
    end_episode();

    do_reset();
    run_inst(32'hFFFF_FFFF, 1'b1, 32'd0, 0, 0, h);
    end_episode();

    do_reset();
    run_inst(32'h0000_0073, 1'b1, 32'd0, 2, 0, h);
    end_episode();

    // fetch watchdog, then MEM watchdog
    do_reset();
    run_inst(32'h0050_0093, 1'b1, 32'd0, 0, 0, h);
    run_inst(32'h0050_0093, 1'b1, 32'd0, T, 0, h);
    end_episode();

    do_reset();
    run_inst(32'h0001_2083, 1'b1, 32'd0, 0, T, h);
    end_episode();

    // valid/ack on the last allowed wait cycle beats the timeout
    do_reset();
    run_inst(32'h0001_2083, 1'b1, 32'd0, T - 1, T - 1, h);
    run_inst(EBRK, 1'b0, 32'd0, 0, 0, h);
    end_episode();

    // 10 back-to-back ALU ops then ebreak
    do_reset();
    for (int n = 0; n < 10; n++) run_inst(32'h0050_0093, 1'b1, 32'd0, 0, 0, h);
    run_inst(EBRK, 1'b0, 32'd0, 0, 0, h);
    end_episode();

    // reset mid-MEM, then confirm normal operation afterwards
    do_reset();
    run_inst(32'h0050_0093, 1'b0, 32'd0, 0, 0, h);
    abort_mem();
    exp_q.delete();
    do_reset();
    run_inst(32'h0050_0093, 1'b1, 32'd0, 0, 0, h);
    run_inst(EBRK, 1'b0, 32'd3, 0, 0, h);
    end_episode();

    // randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      h = 1'b0;
      for (int n = 0; n < 12 && !h; n++) begin
        logic [31:0] ri;
        int fd, md;
        ri = rand_inst();
        fd = ($urandom_range(0, 24) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
        md = ($urandom_range(0, 12) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
        run_inst(ri, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom, fd, md, h);
      end
      if (!h) run_inst(EBRK, 1'b1, ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd1, 0, 0, h);
      end_episode();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
